// File: rtl/gol_engine_if.sv
// gol_engine_if -- control/data bundle for the Game of Life engine.
//   master : drives the seed grid, the command strobes, wrap_mode and max_gen,
//            and observes the generation, counter and status flags.
//   slave  : the engine side, the mirror image of master.
interface gol_engine_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
);
    logic [ROWS*COLS-1:0] grid_in;
    logic                 load;
    logic                 start;
    logic                 step;
    logic                 stop;
    logic                 wrap_mode;
    logic [GEN_W-1:0]     max_gen;
    logic [ROWS*COLS-1:0] q;
    logic [GEN_W-1:0]     gen_count;
    logic                 busy;
    logic                 done;
    logic                 stable;
    logic                 extinct;

    modport master (
        output grid_in, load, start, step, stop, wrap_mode, max_gen,
        input  q, gen_count, busy, done, stable, extinct
    );

    modport slave (
        input  grid_in, load, start, step, stop, wrap_mode, max_gen,
        output q, gen_count, busy, done, stable, extinct
    );
endinterface

// File: rtl/gol_engine.sv
// gol_engine -- Conway's Game of Life on a ROWS x COLS grid.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-low
//   bus   : gol_engine_if.slave (seed grid, load/start/step/stop commands,
//           wrap_mode, max_gen limit; q, gen_count, busy/done/stable/extinct)
// Cell (r,c) lives at bit (ROWS-1-r)*COLS + (COLS-1-c), so row 0 is in the MSBs.
// The next generation is computed combinationally for the whole grid; the
// FSM (IDLE/RUN/DONE) decides when it is committed to q.
module gol_engine #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    gol_engine_if.slave bus
);
    localparam int N = ROWS * COLS;
    localparam logic [GEN_W-1:0] GEN_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [N-1:0]     q_reg;
    logic [N-1:0]     next_grid;
    logic [GEN_W-1:0] gen_reg;
    logic [GEN_W-1:0] gen_next;
    logic             busy_reg;
    logic             done_reg;
    logic             stable_reg;
    logic             extinct_reg;

    // Per-cell neighbour count. Neighbour positions are resolved at
    // elaboration: in-grid neighbours are wired straight to q, off-grid
    // ones are wired to the wrapped cell and gated by wrap_mode.
    genvar gi, gj, gk;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                localparam int SELF = (ROWS-1-gi)*COLS + (COLS-1-gj);
                logic [7:0] nb;
                logic [3:0] cnt;
                for (gk = 0; gk < 8; gk++) begin : g_nb
                    // K walks the 3x3 window row-major, skipping the centre (4)
                    localparam int K      = (gk < 4) ? gk : gk + 1;
                    localparam int RA     = gi + K/3 - 1;
                    localparam int CA     = gj + K%3 - 1;
                    localparam int RW     = (RA + ROWS) % ROWS;
                    localparam int CW     = (CA + COLS) % COLS;
                    localparam int IDX    = (ROWS-1-RW)*COLS + (COLS-1-CW);
                    localparam bit INSIDE = (RA >= 0) && (RA < ROWS) &&
                                            (CA >= 0) && (CA < COLS);
                    if (INSIDE) begin : g_in
                        assign nb[gk] = q_reg[IDX];
                    end else begin : g_edge
                        assign nb[gk] = bus.wrap_mode & q_reg[IDX];
                    end
                end
                assign cnt = 4'($countones(nb));
                assign next_grid[SELF] = (cnt == 4'd3) | (q_reg[SELF] & (cnt == 4'd2));
            end
        end
    endgenerate

    // Saturating increment: the counter never wraps past all ones.
    assign gen_next = (gen_reg == GEN_MAX) ? gen_reg : gen_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            gen_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            stable_reg  <= 1'b0;
            extinct_reg <= 1'b0;
        end else if (bus.load) begin
            state_reg   <= IDLE;
            q_reg       <= bus.grid_in;
            gen_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            stable_reg  <= 1'b0;
            extinct_reg <= 1'b0;
        end else if (bus.stop) begin
            // In IDLE this is a no-op (flags are already clear there), but it
            // still masks start/step so the priority order holds.
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            stable_reg  <= 1'b0;
            extinct_reg <= 1'b0;
        end else if (bus.start && state_reg != RUN) begin
            state_reg   <= RUN;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            stable_reg  <= 1'b0;
            extinct_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.step) begin
                        q_reg   <= next_grid;
                        gen_reg <= gen_next;
                    end
                end
                RUN: begin
                    if (q_reg == '0) begin
                        extinct_reg <= 1'b1;
                        state_reg   <= DONE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                    end else if (next_grid == q_reg) begin
                        stable_reg <= 1'b1;
                        state_reg  <= DONE;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                    end else begin
                        q_reg   <= next_grid;
                        gen_reg <= gen_next;
                        if ((bus.max_gen != '0 && gen_next == bus.max_gen) ||
                            gen_next == GEN_MAX) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // q and flags frozen until load, stop or start
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q         = q_reg;
    assign bus.gen_count = gen_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.stable    = stable_reg;
    assign bus.extinct   = extinct_reg;
endmodule
